// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl
//
// Sampling controller for a free-running ring-oscillator entropy source.
// It releases the ring generator from reset, lets it warm up, then
// decimates its serial output into WORD_W-bit words. Each word is offered
// on a valid/ready port and held there until the consumer takes it.
//
// Handshake: a word transfers on every rising edge where
// data_valid & data_ready are both high. While data_valid is high,
// data_out and data_valid do not change until that transfer happens.
// The only exceptions are enable=0, a health fault, or rst.
//
// Optional feature macro: TRNG_HEALTH_TEST_EN
//   When it is defined, a repetition-count health test runs on the sample
//   stream. A run of REP_LIMIT identical samples parks the block in FAULT
//   and sets the sticky health_fail flag. The block leaves FAULT only
//   through IDLE, via enable=0 or rst. When the macro is undefined, FAULT
//   cannot be reached and health_fail stays 0.
//
// Parameters:
//   WARMUP_CYCLES  cycles the ring runs after release before sampling (1..65535)
//   DECIM          clocks per sampled bit (1..255)
//   WORD_W         bits per output word (2..64)
//   REP_LIMIT      identical-sample run length treated as a fault (2..255)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   enable       level-sensitive run request
//   rg_bit       serial output of the ring generator
//   rg_rst       reset driven to the ring generator (high in IDLE and FAULT)
//   data_out     collected random word
//   data_valid   data_out holds a word
//   data_ready   consumer accepts the word
//   health_fail  sticky repetition-test fault
//   busy         high whenever the FSM is not in IDLE
//   state_dbg    current FSM state:
//                0 IDLE, 1 WARMUP, 2 COLLECT, 3 HOLD, 4 FAULT
module trng_sample_ctrl #(
   parameter int WARMUP_CYCLES = 256,
   parameter int DECIM         = 4,
   parameter int WORD_W        = 32,
   parameter int REP_LIMIT     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              rg_bit,
   output logic              rg_rst,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              health_fail,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WARMUP  = 3'd1,
      S_COLLECT = 3'd2,
      S_HOLD    = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   state_t            state_q, state_n;
   logic [15:0]       warm_q, warm_n;
   logic [7:0]        dec_q, dec_n;
   logic [6:0]        bit_q, bit_n;
   logic [WORD_W-1:0] shreg_q, shreg_n;
   logic [WORD_W-1:0] dout_n;
   logic              dvalid_n;
   logic              hfail_n;
   logic              rg_rst_n;
   logic              sample_now;
   logic              fault_hit;
   logic [WORD_W-1:0] word_next;

`ifdef TRNG_HEALTH_TEST_EN
   logic [7:0] run_q, run_n;
   logic       prev_q, prev_n;
   logic [7:0] run_step;
`endif

   always_comb begin
      state_n    = state_q;
      warm_n     = warm_q;
      dec_n      = dec_q;
      bit_n      = bit_q;
      shreg_n    = shreg_q;
      dout_n     = data_out;
      dvalid_n   = data_valid;
      hfail_n    = health_fail;
      fault_hit  = 1'b0;
      sample_now = (dec_q == 8'(DECIM - 1));
      // New bits enter at the LSB, so the first sample of a word ends up at the MSB.
      word_next  = {shreg_q[WORD_W-2:0], rg_bit};
`ifdef TRNG_HEALTH_TEST_EN
      run_n    = run_q;
      prev_n   = prev_q;
      // A run count of zero means there is no previous sample yet, so the
      // first sample after warm-up always starts a new run.
      run_step = (run_q != 8'd0 && rg_bit == prev_q) ? run_q + 8'd1 : 8'd1;
`endif

      case (state_q)
         S_IDLE: begin
            warm_n   = '0;
            dec_n    = '0;
            bit_n    = '0;
            shreg_n  = '0;
            dvalid_n = 1'b0;
            hfail_n  = 1'b0;
`ifdef TRNG_HEALTH_TEST_EN
            run_n    = '0;
            prev_n   = 1'b0;
`endif
            if (enable) state_n = S_WARMUP;
         end
         S_WARMUP: begin
            if (warm_q == 16'(WARMUP_CYCLES - 1)) begin
               state_n = S_COLLECT;
               warm_n  = '0;
               dec_n   = '0;
               bit_n   = '0;
               shreg_n = '0;
`ifdef TRNG_HEALTH_TEST_EN
               run_n   = '0;
`endif
            end else begin
               warm_n = warm_q + 16'd1;
            end
         end
         S_COLLECT: begin
            if (sample_now) begin
               dec_n   = '0;
               shreg_n = word_next;
               bit_n   = bit_q + 7'd1;
`ifdef TRNG_HEALTH_TEST_EN
               run_n     = run_step;
               prev_n    = rg_bit;
               fault_hit = (run_step == 8'(REP_LIMIT));
`endif
               // The health check wins over word completion, so a fault on
               // the last bit of a word suppresses that word.
               if (fault_hit) begin
                  state_n  = S_FAULT;
                  hfail_n  = 1'b1;
                  dvalid_n = 1'b0;
                  shreg_n  = '0;
                  bit_n    = '0;
               end else if (bit_q == 7'(WORD_W - 1)) begin
                  state_n = S_HOLD;
                  dout_n  = word_next;
                  shreg_n = '0;
                  bit_n   = '0;
               end
            end else begin
               dec_n = dec_q + 8'd1;
            end
         end
         S_HOLD: begin
            // The first HOLD cycle raises data_valid. The word then sits
            // here until it is taken.
            if (!data_valid) begin
               dvalid_n = 1'b1;
            end else if (data_ready) begin
               dvalid_n = 1'b0;
               state_n  = S_COLLECT;
               dec_n    = '0;
               bit_n    = '0;
            end
         end
         S_FAULT: ;
         default: state_n = S_IDLE;
      endcase

      // Dropping enable overrides everything else. A transfer in the same
      // cycle still completes because data_valid falls either way.
      if (state_q != S_IDLE && !enable) begin
         state_n  = S_IDLE;
         warm_n   = '0;
         dec_n    = '0;
         bit_n    = '0;
         shreg_n  = '0;
         dout_n   = data_out;
         dvalid_n = 1'b0;
         hfail_n  = 1'b0;
`ifdef TRNG_HEALTH_TEST_EN
         run_n    = '0;
         prev_n   = 1'b0;
`endif
      end

      rg_rst_n = (state_n == S_IDLE) || (state_n == S_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         warm_q      <= '0;
         dec_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         rg_rst      <= 1'b1;
         data_out    <= '0;
         data_valid  <= 1'b0;
         health_fail <= 1'b0;
         busy        <= 1'b0;
`ifdef TRNG_HEALTH_TEST_EN
         run_q       <= '0;
         prev_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_n;
         warm_q      <= warm_n;
         dec_q       <= dec_n;
         bit_q       <= bit_n;
         shreg_q     <= shreg_n;
         rg_rst      <= rg_rst_n;
         data_out    <= dout_n;
         data_valid  <= dvalid_n;
         health_fail <= hfail_n;
         busy        <= (state_n != S_IDLE);
`ifdef TRNG_HEALTH_TEST_EN
         run_q       <= run_n;
         prev_q      <= prev_n;
`endif
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// tb_trng_sample_ctrl
//
// Bench for trng_sample_ctrl with WARMUP_CYCLES=4, DECIM=4, WORD_W=8 and
// REP_LIMIT=8.
//
// The bench drives rg_bit one decimation window at a time, starting at
// the first COLLECT cycle, so each sample is stable over its whole
// window. The stimulus sequences are given in time order, with bit 0
// sampled first. Expected words come from a table of constants or from a
// stream model that packs samples MSB-first and tracks identical-sample
// runs.
module tb_trng_sample_ctrl;

   localparam int WARMUP_CYCLES = 4;
   localparam int DECIM         = 4;
   localparam int WORD_W        = 8;
   localparam int REP_LIMIT     = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WARMUP  = 3'd1;
   localparam logic [2:0] ST_COLLECT = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_FAULT   = 3'd4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic              rg_bit;
   logic              rg_rst;
   logic [WORD_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              health_fail;
   logic              busy;
   logic [2:0]        state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   logic [WORD_W-1:0] exp_q[$];
   logic [WORD_W-1:0] last_word = '0;

   typedef struct {
      logic [7:0] seq;   // samples in time order, bit 0 first
      logic [7:0] exp;   // word expected on data_out
      int         hold;  // cycles data_ready stays low after valid
   } vec_t;

   vec_t tbl [6];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   trng_sample_ctrl #(
      .WARMUP_CYCLES (WARMUP_CYCLES),
      .DECIM         (DECIM),
      .WORD_W        (WORD_W),
      .REP_LIMIT     (REP_LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .rg_bit      (rg_bit),
      .rg_rst      (rg_rst),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .health_fail (health_fail),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_bits(input logic [7:0] seq);
      for (int k = 0; k < WORD_W; k++) begin
         rg_bit = seq[k];
         repeat (DECIM) @(negedge clk);
      end
   endtask

   task automatic wait_valid(output int waited);
      waited = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (data_valid === 1'b1) begin
            waited = i;
            break;
         end
      end
   endtask

   task automatic start_run();
      enable = 1'b1;
      @(negedge clk);
      check("warmup_entered", state_dbg, ST_WARMUP);
      check("warmup_rg_rst_low", rg_rst, 1'b0);
      check("warmup_busy", busy, 1'b1);
      repeat (WARMUP_CYCLES - 1) @(negedge clk);
      check("warmup_length", state_dbg, ST_WARMUP);
      @(negedge clk);
      check("collect_entered", state_dbg, ST_COLLECT);
   endtask

   task automatic stop_run();
      enable = 1'b0;
      @(negedge clk);
      check("idle_state", state_dbg, ST_IDLE);
      check("idle_rg_rst", rg_rst, 1'b1);
      check("idle_valid", data_valid, 1'b0);
      check("idle_health", health_fail, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_dout_held", data_out, last_word);
   endtask

   // lead: edges already elapsed since the reference event (enable rise
   // or previous transfer edge); exp_lat: required edges up to data_valid.
   task automatic xfer_word(input string name, input logic [7:0] seq, input int hold,
                            input int lead, input int exp_lat);
      int waited;
      logic [7:0] exp;
      exp = exp_q.pop_front();
      data_ready = (hold == 0);
      drive_bits(seq);
      check({name, "_no_early_valid"}, data_valid, 1'b0);
      wait_valid(waited);
      check({name, "_latency"}, (waited < 0) ? -1 : lead + WORD_W * DECIM + waited, exp_lat);
      check({name, "_data"}, data_out, exp);
      check({name, "_state_hold"}, state_dbg, ST_HOLD);
      for (int h = 0; h < hold; h++) begin
         rg_bit = 1'($urandom);
         @(negedge clk);
         check({name, "_hold_stable"}, {data_valid, data_out}, {1'b1, exp});
      end
      data_ready = 1'b1;
      @(negedge clk);
      check({name, "_valid_drop"}, data_valid, 1'b0);
      check({name, "_back_to_collect"}, state_dbg, ST_COLLECT);
      last_word = exp;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int         waited;
      int         fresh;
      int         hold;
      int         fault_at;
      int         m_run;
      logic       m_last;
      logic [7:0] seq;
      logic [7:0] w;

      tbl[0] = '{8'h4D, 8'hB2, 0};  // samples 1,0,1,1,0,0,1,0
      tbl[1] = '{8'h01, 8'h80, 5};  // consumer stalls while the word is held
      tbl[2] = '{8'h7F, 8'hFE, 0};
      tbl[3] = '{8'hAA, 8'h55, 1};
      tbl[4] = '{8'hC3, 8'hC3, 0};
      tbl[5] = '{8'h96, 8'h69, 2};

      rst        = 1'b1;
      enable     = 1'b0;
      rg_bit     = 1'b0;
      data_ready = 1'b1;
      m_run      = 0;
      m_last     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_rg_rst", rg_rst, 1'b1);
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_health", health_fail, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_enable", state_dbg, ST_IDLE);

      // Table vectors, back to back after one enable
      start_run();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(tbl[i].exp);
         xfer_word($sformatf("tbl%0d", i), tbl[i].seq, tbl[i].hold,
                   (i == 0) ? 1 + WARMUP_CYCLES : 0, (i == 0) ? 38 : 33);
      end
      stop_run();

      // Abort after five samples, then restart with a fresh warm-up
      start_run();
      rg_bit = 1'b0;
      repeat (5 * DECIM) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("abort_idle", state_dbg, ST_IDLE);
      check("abort_valid", data_valid, 1'b0);
      check("abort_rg_rst", rg_rst, 1'b1);
      check("abort_dout_held", data_out, 8'h69);
      start_run();
      exp_q.push_back(8'hB2);
      xfer_word("restart", 8'h4D, 0, 1 + WARMUP_CYCLES, 38);
      stop_run();

`ifdef TRNG_HEALTH_TEST_EN
      // Stuck-at-1 source: fault exactly on the 8th sample edge
      start_run();
      rg_bit = 1'b1;
      repeat (REP_LIMIT * DECIM - 1) @(negedge clk);
      check("stuck_no_fault_yet", health_fail, 1'b0);
      check("stuck_collect_yet", state_dbg, ST_COLLECT);
      @(negedge clk);
      check("stuck_health_fail", health_fail, 1'b1);
      check("stuck_rg_rst", rg_rst, 1'b1);
      check("stuck_state_fault", state_dbg, ST_FAULT);
      check("stuck_no_valid", data_valid, 1'b0);
      waited = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (data_valid === 1'b1) waited++;
      end
      check("stuck_no_word", waited, 0);
      check("stuck_fault_sticky", {state_dbg, health_fail}, {ST_FAULT, 1'b1});
      stop_run();
`else
      // Stuck-at-1 source without the health test: words of all ones
      start_run();
      exp_q.push_back(8'hFF);
      xfer_word("ones0", 8'hFF, 0, 1 + WARMUP_CYCLES, 38);
      check("ones0_health", health_fail, 1'b0);
      exp_q.push_back(8'hFF);
      xfer_word("ones1", 8'hFF, 0, 0, 33);
      check("ones1_health", health_fail, 1'b0);
      stop_run();
`endif

      // Randomized words against the stream model
      start_run();
      fresh = 1;
      m_run = 0;
      for (int n = 0; n < 24; n++) begin
         seq      = 8'($urandom);
         hold     = $urandom_range(3, 0);
         w        = '0;
         fault_at = -1;
         for (int k = 0; k < WORD_W; k++) begin
`ifdef TRNG_HEALTH_TEST_EN
            if (m_run > 0 && seq[k] == m_last) m_run++;
            else m_run = 1;
            m_last = seq[k];
            if (m_run >= REP_LIMIT && fault_at < 0) fault_at = k;
`endif
            w = 8'((w * 2) + seq[k]);
         end
         if (fault_at >= 0) begin
            data_ready = 1'b1;
            drive_bits(seq);
            check("rand_fault_flag", health_fail, 1'b1);
            check("rand_fault_state", state_dbg, ST_FAULT);
            check("rand_fault_valid", data_valid, 1'b0);
            stop_run();
            start_run();
            m_run = 0;
            fresh = 1;
         end else begin
            exp_q.push_back(w);
            xfer_word("rand", seq, hold, fresh ? 1 + WARMUP_CYCLES : 0, fresh ? 38 : 33);
            fresh = 0;
         end
      end
      stop_run();

      // Asynchronous reset while a word is held
      start_run();
      data_ready = 1'b0;
      drive_bits(8'h4D);
      wait_valid(waited);
      check("arst_valid_latency", waited, 1);
      check("arst_hold_data", data_out, 8'hB2);
      #2 rst = 1'b1;
      #1;
      check("arst_data_out", data_out, 8'h00);
      check("arst_valid", data_valid, 1'b0);
      check("arst_rg_rst", rg_rst, 1'b1);
      check("arst_busy", busy, 1'b0);
      check("arst_state", state_dbg, ST_IDLE);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("arst_after_release", {state_dbg, data_valid, data_out}, {ST_IDLE, 1'b0, 8'h00});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
